branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter XLEN, default 32: address/data width.
REQ-002 Parameter CNT_W, default 16: width of statistics counters.
REQ-003 clk  in  1: the single clock; all state updates on rising edge.
REQ-004 rst  in  1: reset, synchronous and active-high.
REQ-005 ex_valid  in  1: decode/execute stage holds a valid instruction this cycle.
REQ-006 ex_is_br  in  1: that instruction is a branch/jump.
REQ-007 br_type  in  3: comparator branch code: 000 eq, 001 ne, 010 lt, 011 ge, 100 ltu, 101 geu, 111 unconditional, 110 illegal.
REQ-008 br_taken  in  1: comparator result for the current ex instruction.
REQ-009 br_target  in  XLEN: computed target address.
REQ-010 stall  in  1: fetch cannot accept a new PC this cycle.
REQ-011 pc_sel  out  1: 1 = PC mux selects pc_redirect.
REQ-012 pc_redirect  out  XLEN: latched redirect target.
REQ-013 flush_if  out  1: squash the instruction in fetch.
REQ-014 flush_de  out  1: squash the instruction in decode/execute.
REQ-015 br_cnt, taken_cnt  out  CNT_W each: resolved and taken branch counts.
REQ-016 br_illegal  out  1: sticky flag, illegal br_type seen on a valid branch.

Function
REQ-017 Static not-taken policy; every taken resolution is a redirect.
REQ-018 FSM has two states, IDLE and REDIRECT; all outputs registered.
REQ-019 Resolve event: state IDLE and ex_valid=1 and ex_is_br=1.
REQ-020 Taken-resolve: resolve event with br_type=111, or with br_taken=1 and br_type not 110.
REQ-021 Taken-resolve in cycle N: latch br_target into pc_redirect; enter REDIRECT at N+1.
REQ-022 In REDIRECT: pc_sel=1, flush_if=1, flush_de=1.
REQ-023 REDIRECT with stall=1: stay in REDIRECT, hold pc_redirect and all three outputs.
REQ-024 REDIRECT with stall=0: return to IDLE next cycle; redirect pulse lasts exactly one unstalled cycle.
REQ-025 In REDIRECT, ex_valid/ex_is_br/br_taken ignored (wrong path): no latch, no count.
REQ-026 In IDLE: pc_sel=0, flush_if=0, flush_de=0; pc_redirect holds its last value.
REQ-027 br_type=110 on a resolve event: treated as not taken; br_illegal set and held until rst.
REQ-028 br_cnt increments on every resolve event, including illegal ones.
REQ-029 taken_cnt increments on every taken-resolve.
REQ-030 Counters wrap modulo 2^CNT_W; no saturation.
REQ-031 stall has no effect in IDLE; resolve events are still accepted.

Reset
REQ-032 rst=1 at a rising edge: state IDLE; pc_sel, flush_if, flush_de, br_illegal = 0; pc_redirect, br_cnt, taken_cnt = 0.
REQ-033 rst overrides everything: rst during REDIRECT, even with stall=1, aborts the redirect with no further pulse.
REQ-034 Resolve events in a cycle with rst=1 are dropped.

Structure
REQ-035 Shared pipeline package holds the br_type code constants and the FSM state enum; branch_ctrl and the branch comparator both import them.
REQ-036 Single module, no sub-modules; the counter pair may be one generic counter instantiated twice.

Verification
REQ-037 IDLE, ex_valid=1, ex_is_br=1, br_type=000, br_taken=1, br_target=0x100 at N -> N+1: pc_sel=flush_if=flush_de=1, pc_redirect=0x100; N+2: all 0; br_cnt=1, taken_cnt=1.
REQ-038 Taken branch at N with stall=1 for N+1..N+3 -> pc_sel held high N+1..N+4, IDLE at N+5; a branch presented at N+2 is not counted.
REQ-039 br_type=110, br_taken=1 -> no redirect; br_illegal=1 persisting; br_cnt+1, taken_cnt unchanged.
REQ-040 br_type=111, br_taken=0 -> redirect taken; br_type=001, br_taken=0 -> no redirect, br_cnt+1 only.
REQ-041 rst asserted during stalled REDIRECT -> next cycle all outputs 0, counters 0, IDLE.
REQ-042 Preload br_cnt=0xFFFF via 65535 not-taken branches, then one more -> br_cnt=0x0000.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared pipeline definitions for branch resolution.
// Holds the comparator branch-type codes, the redirect FSM state enum and
// the taken-decision helper. The comparator and branch_ctrl both import it.
package branch_ctrl_pkg;

  typedef logic [2:0] br_type_t;

  localparam br_type_t BR_EQ      = 3'b000;
  localparam br_type_t BR_NE      = 3'b001;
  localparam br_type_t BR_LT      = 3'b010;
  localparam br_type_t BR_GE      = 3'b011;
  localparam br_type_t BR_LTU     = 3'b100;
  localparam br_type_t BR_GEU     = 3'b101;
  localparam br_type_t BR_ILLEGAL = 3'b110;
  localparam br_type_t BR_UNCOND  = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } br_state_e;

  // Unconditional jumps always redirect; an illegal code never does,
  // whatever the comparator reports.
  function automatic logic br_is_taken(input br_type_t t, input logic taken);
    return (t == BR_UNCOND) || (taken && (t != BR_ILLEGAL));
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Execute/fetch <-> branch controller bundle.
//   master : execute stage + fetch (drives ex_*, br_*, stall; sees redirect)
//   slave  : branch_ctrl (drives redirect, flushes, statistics)
// Signals:
//   ex_valid, ex_is_br, br_type, br_taken, br_target, stall  (to controller)
//   pc_sel, pc_redirect, flush_if, flush_de                  (redirect)
//   br_cnt, taken_cnt, br_illegal                            (statistics)
interface branch_ctrl_if
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_is_br;
  br_type_t         br_type;
  logic             br_taken;
  logic [XLEN-1:0]  br_target;
  logic             stall;

  logic             pc_sel;
  logic [XLEN-1:0]  pc_redirect;
  logic             flush_if;
  logic             flush_de;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic             br_illegal;

  modport master (
    output ex_valid, ex_is_br, br_type, br_taken, br_target, stall,
    input  pc_sel, pc_redirect, flush_if, flush_de,
           br_cnt, taken_cnt, br_illegal
  );

  modport slave (
    input  ex_valid, ex_is_br, br_type, br_taken, br_target, stall,
    output pc_sel, pc_redirect, flush_if, flush_de,
           br_cnt, taken_cnt, br_illegal
  );
endinterface

// File: rtl/branch_ctrl_counter.sv
// Generic wrapping event counter.
//   clk, rst : clock, synchronous active-high clear
//   inc      : count one event this cycle
//   cnt      : current count, wraps modulo 2^W
module branch_ctrl_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/branch_ctrl.sv
// Branch redirect controller, static not-taken prediction.
// A taken resolution latches the target and enters REDIRECT, which drives
// pc_sel/flush_if/flush_de until fetch accepts the new PC (stall low).
// Instructions seen during REDIRECT are wrong-path and ignored.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_ctrl_if slave (inputs from execute/fetch, redirect
//              outputs, resolved/taken counters, sticky illegal flag)
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  branch_ctrl_if.slave  bus
);

  br_state_e       state_q, state_d;
  logic            resolve;
  logic            take;
  logic            redir_q;
  logic            illegal_q;
  logic [XLEN-1:0] target_q;

  always_comb begin
    state_d = state_q;
    resolve = 1'b0;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        resolve = bus.ex_valid && bus.ex_is_br;
        take    = resolve && br_is_taken(bus.br_type, bus.br_taken);
        if (take) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (!bus.stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Redirect outputs come from their own flop, loaded with the next-state
  // decode, so they are registered and line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      redir_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= (state_d == ST_REDIRECT);
      if (take) target_q <= bus.br_target;
      if (resolve && (bus.br_type == BR_ILLEGAL)) illegal_q <= 1'b1;
    end
  end

  branch_ctrl_counter #(.W(CNT_W)) u_br_cnt (
    .clk (clk),
    .rst (rst),
    .inc (resolve),
    .cnt (bus.br_cnt)
  );

  branch_ctrl_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .rst (rst),
    .inc (take),
    .cnt (bus.taken_cnt)
  );

  assign bus.pc_sel      = redir_q;
  assign bus.flush_if    = redir_q;
  assign bus.flush_de    = redir_q;
  assign bus.pc_redirect = target_q;
  assign bus.br_illegal  = illegal_q;

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [XLEN-1:0] tgt;
    int              len;
  } exp_t;

  exp_t sbq[$];

  branch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bif ();

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Present one cycle of inputs, then move to just after the consuming edge.
  task automatic cyc(input logic v, input logic b, input br_type_t t, input logic tk,
                     input logic [XLEN-1:0] tgt, input logic st, input logic r);
    bif.ex_valid  = v;
    bif.ex_is_br  = b;
    bif.br_type   = t;
    bif.br_taken  = tk;
    bif.br_target = tgt;
    bif.stall     = st;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, 1'b0, BR_EQ, 1'b0, '0, st, 1'b0);
  endtask

  task automatic expect_redirect(input logic [XLEN-1:0] tgt, input int len);
    exp_t e;
    e.tgt = tgt;
    e.len = len;
    sbq.push_back(e);
  endtask

  // Monitor: every redirect pulse is matched against the scoreboard for
  // target, flushes and number of cycles held high.
  logic m_prev = 1'b0;
  int   m_hi   = 0;
  exp_t m_cur;

  initial begin
    m_cur.tgt = '0;
    m_cur.len = 0;
    forever begin
      @(negedge clk);
      if (bif.pc_sel === 1'b1) begin
        if (!m_prev) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_redirect: got target %0h want no redirect", bif.pc_redirect);
            m_cur.tgt = bif.pc_redirect;
            m_cur.len = 0;
          end else begin
            m_cur = sbq.pop_front();
            chk("redirect_target", 64'(bif.pc_redirect), 64'(m_cur.tgt));
          end
          chk("flush_if_on", 64'(bif.flush_if), 64'd1);
          chk("flush_de_on", 64'(bif.flush_de), 64'd1);
          m_hi = 1;
        end else begin
          m_hi++;
          chk("redirect_hold", 64'(bif.pc_redirect), 64'(m_cur.tgt));
        end
        m_prev = 1'b1;
      end else begin
        if (m_prev) begin
          chk("redirect_len", 64'(m_hi), 64'(m_cur.len));
          chk("flush_if_off", 64'(bif.flush_if), 64'd0);
          chk("flush_de_off", 64'(bif.flush_de), 64'd0);
        end
        m_prev = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    cyc(1'b0, 1'b0, BR_EQ, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, BR_EQ, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_pc_sel",      64'(bif.pc_sel), 64'd0);
    chk("rst_flush_if",    64'(bif.flush_if), 64'd0);
    chk("rst_flush_de",    64'(bif.flush_de), 64'd0);
    chk("rst_pc_redirect", 64'(bif.pc_redirect), 64'd0);
    chk("rst_br_cnt",      64'(bif.br_cnt), 64'd0);
    chk("rst_taken_cnt",   64'(bif.taken_cnt), 64'd0);
    chk("rst_br_illegal",  64'(bif.br_illegal), 64'd0);

    // basic taken beq
    expect_redirect(32'h100, 1);
    cyc(1'b1, 1'b1, BR_EQ, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("beq_pc_sel",   64'(bif.pc_sel), 64'd1);
    chk("beq_redirect", 64'(bif.pc_redirect), 64'h100);
    idle(1'b0);
    chk("beq_pc_sel_off", 64'(bif.pc_sel), 64'd0);
    chk("beq_br_cnt",     64'(bif.br_cnt), 64'd1);
    chk("beq_taken_cnt",  64'(bif.taken_cnt), 64'd1);

    // stalled redirect, wrong-path branch ignored
    expect_redirect(32'h200, 4);
    cyc(1'b1, 1'b1, BR_EQ, 1'b1, 32'h200, 1'b0, 1'b0);
    idle(1'b1);
    cyc(1'b1, 1'b1, BR_EQ, 1'b1, 32'h300, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("stall_pc_sel_off", 64'(bif.pc_sel), 64'd0);
    chk("stall_br_cnt",     64'(bif.br_cnt), 64'd2);
    chk("stall_taken_cnt",  64'(bif.taken_cnt), 64'd2);
    chk("idle_redirect_hold", 64'(bif.pc_redirect), 64'h200);

    // illegal code: not taken, sticky flag
    cyc(1'b1, 1'b1, BR_ILLEGAL, 1'b1, 32'h999, 1'b0, 1'b0);
    chk("ill_pc_sel",    64'(bif.pc_sel), 64'd0);
    chk("ill_flag",      64'(bif.br_illegal), 64'd1);
    chk("ill_br_cnt",    64'(bif.br_cnt), 64'd3);
    chk("ill_taken_cnt", 64'(bif.taken_cnt), 64'd2);
    idle(1'b0);
    idle(1'b0);
    chk("ill_flag_sticky", 64'(bif.br_illegal), 64'd1);

    // unconditional with br_taken=0 redirects; bne not taken does not
    expect_redirect(32'h400, 1);
    cyc(1'b1, 1'b1, BR_UNCOND, 1'b0, 32'h400, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b1, 1'b1, BR_NE, 1'b0, 32'h444, 1'b0, 1'b0);
    chk("bne_nt_pc_sel",    64'(bif.pc_sel), 64'd0);
    chk("bne_nt_br_cnt",    64'(bif.br_cnt), 64'd5);
    chk("bne_nt_taken_cnt", 64'(bif.taken_cnt), 64'd3);

    // stall in IDLE does not block resolution
    expect_redirect(32'h500, 1);
    cyc(1'b1, 1'b1, BR_LT, 1'b1, 32'h500, 1'b1, 1'b0);
    idle(1'b0);
    chk("idle_stall_br_cnt",    64'(bif.br_cnt), 64'd6);
    chk("idle_stall_taken_cnt", 64'(bif.taken_cnt), 64'd4);

    // non-branch or invalid slots are not resolve events
    cyc(1'b1, 1'b0, BR_EQ, 1'b1, 32'h700, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, BR_EQ, 1'b1, 32'h700, 1'b0, 1'b0);
    chk("nonbr_pc_sel",    64'(bif.pc_sel), 64'd0);
    chk("nonbr_br_cnt",    64'(bif.br_cnt), 64'd6);
    chk("nonbr_taken_cnt", 64'(bif.taken_cnt), 64'd4);

    // reset during stalled redirect aborts it
    expect_redirect(32'h600, 2);
    cyc(1'b1, 1'b1, BR_LTU, 1'b1, 32'h600, 1'b0, 1'b0);
    idle(1'b1);
    cyc(1'b1, 1'b1, BR_EQ, 1'b1, 32'h6f0, 1'b1, 1'b1);
    chk("rstr_pc_sel",      64'(bif.pc_sel), 64'd0);
    chk("rstr_flush_if",    64'(bif.flush_if), 64'd0);
    chk("rstr_flush_de",    64'(bif.flush_de), 64'd0);
    chk("rstr_pc_redirect", 64'(bif.pc_redirect), 64'd0);
    chk("rstr_br_cnt",      64'(bif.br_cnt), 64'd0);
    chk("rstr_taken_cnt",   64'(bif.taken_cnt), 64'd0);
    chk("rstr_br_illegal",  64'(bif.br_illegal), 64'd0);

    // resolve event under reset in IDLE is dropped
    cyc(1'b1, 1'b1, BR_EQ, 1'b1, 32'h800, 1'b0, 1'b1);
    chk("rst_drop_pc_sel",  64'(bif.pc_sel), 64'd0);
    chk("rst_drop_br_cnt",  64'(bif.br_cnt), 64'd0);
    chk("rst_drop_redirect", 64'(bif.pc_redirect), 64'd0);

    // counter wrap
    for (int i = 0; i < 65535; i++)
      cyc(1'b1, 1'b1, BR_EQ, 1'b0, 32'h900, 1'b0, 1'b0);
    chk("wrap_pre_br_cnt",    64'(bif.br_cnt), 64'hFFFF);
    chk("wrap_pre_taken_cnt", 64'(bif.taken_cnt), 64'd0);
    cyc(1'b1, 1'b1, BR_GE, 1'b0, 32'h900, 1'b0, 1'b0);
    chk("wrap_br_cnt",    64'(bif.br_cnt), 64'd0);
    chk("wrap_taken_cnt", 64'(bif.taken_cnt), 64'd0);
    chk("wrap_pc_sel",    64'(bif.pc_sel), 64'd0);

    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
